// File: rtl/noc_send_arbiter.sv
// Packet-atomic round-robin injection arbiter for one network send port, gated per VC by peek flow control.
// Optional watchdog abort of a stalled packet when NOC_ARB_WDOG_EN is defined.
module noc_send_arbiter_lane #(
  parameter int DATA_W  = 32,
  parameter int VC_W    = 1,
  parameter int NUM_VCS = 2,
  parameter int FW      = 36
) (
  input  logic [FW-1:0]      flit,
  input  logic               valid,
  input  logic [NUM_VCS-1:0] nonfull_vcs,
  input  logic [NUM_VCS-1:0] holdoff,
  output logic               elig
);
  logic [VC_W-1:0] vc;
  assign vc = flit[DATA_W +: VC_W];

  // A VC outside the non-full vector can never be sent.
  always_comb begin
    elig = 1'b0;
    for (int v = 0; v < NUM_VCS; v++)
      if (vc == VC_W'(v)) elig = valid & nonfull_vcs[v] & ~holdoff[v];
  end
endmodule

module noc_send_arbiter #(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_W      = 32,
  parameter  int DEST_W      = 2,
  parameter  int VC_W        = 1,
  parameter  int NUM_VCS     = 2,
  parameter  int WDOG_CYCLES = 64,
  localparam int FW          = 2 + DEST_W + VC_W + DATA_W,
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                  INIT_CLK,
  input  logic                  RESET,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*FW-1:0] req_flit,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_VCS-1:0]    nonfull_vcs,
  output logic [FW-1:0]         flit_out,
  output logic                  en_put_flit,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  locked,
  output logic                  wdog_err
);
  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 1) begin : g_bad_params
    $error("noc_send_arbiter: parameter out of range");
  end

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d, grant_idx_q, grant_idx_d;
  logic [NUM_VCS-1:0]   holdoff_q, holdoff_d;
  logic [FW-1:0]        flit_out_q, flit_out_d;
  logic                 en_put_q, en_put_d, wdog_err_q, wdog_err_d;
  logic [NUM_REQ-1:0]   elig;
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [FW-1:0]        win_flit;
  logic [VC_W-1:0]      win_vc;
  int                   j;
`ifdef NOC_ARB_WDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
  logic [CNT_W-1:0]     cnt_q, cnt_d;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    noc_send_arbiter_lane #(.DATA_W(DATA_W), .VC_W(VC_W), .NUM_VCS(NUM_VCS), .FW(FW)) u_lane (
      .flit(req_flit[i*FW +: FW]), .valid(req_valid[i]), .nonfull_vcs(nonfull_vcs),
      .holdoff(holdoff_q), .elig(elig[i]));
  end

  function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // Descending scan so the last hit is the first eligible at or after rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    if (state_q == S_LOCKED) begin
      win_idx   = grant_idx_q;
      win_found = elig[grant_idx_q];
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        j = int'(rr_ptr_q) + k;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        if (elig[j]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(j);
        end
      end
    end
    if (RESET) win_found = 1'b0;
    req_ready          = '0;
    req_ready[win_idx] = win_found;
  end

  assign win_flit = req_flit[int'(win_idx)*FW +: FW];
  assign win_vc   = win_flit[DATA_W +: VC_W];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    holdoff_d   = '0;
    en_put_d    = win_found;
    flit_out_d  = {1'b0, flit_out_q[FW-2:0]};
    wdog_err_d  = 1'b0;
`ifdef NOC_ARB_WDOG_EN
    cnt_d       = '0;
`endif
    if (win_found) begin
      flit_out_d  = {1'b1, win_flit[FW-2:0]};
      grant_idx_d = win_idx;
      for (int v = 0; v < NUM_VCS; v++)
        if (win_vc == VC_W'(v)) holdoff_d[v] = 1'b1;
      if (win_flit[FW-2]) begin
        state_d  = S_IDLE;
        rr_ptr_d = nxt(win_idx);
      end else begin
        state_d  = S_LOCKED;
      end
    end
`ifdef NOC_ARB_WDOG_EN
    else if (state_q == S_LOCKED) begin
      if (cnt_q == CNT_W'(WDOG_CYCLES - 1)) begin
        wdog_err_d = 1'b1;
        state_d    = S_IDLE;
        rr_ptr_d   = nxt(grant_idx_q);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge INIT_CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      holdoff_q   <= '0;
      flit_out_q  <= '0;
      en_put_q    <= 1'b0;
      wdog_err_q  <= 1'b0;
`ifdef NOC_ARB_WDOG_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      holdoff_q   <= holdoff_d;
      flit_out_q  <= flit_out_d;
      en_put_q    <= en_put_d;
      wdog_err_q  <= wdog_err_d;
`ifdef NOC_ARB_WDOG_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign flit_out    = flit_out_q;
  assign en_put_flit = en_put_q;
  assign grant_idx   = grant_idx_q;
  assign locked      = (state_q == S_LOCKED);
  assign wdog_err    = wdog_err_q;
endmodule
